// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synth register bus responder.
// Holds the voice register map offsets, the 24-bit field geometry, the
// WaveType encoding, default address map parameters and a decode helper.
package synth_bus_pkg;

  localparam int FIELD_W    = 24;
  localparam int NUM_FIELDS = 6;

  localparam logic [15:0] DEF_BASE_ADDR    = 16'h0010;
  localparam logic [15:0] DEF_VOICE_STRIDE = 16'h0020;

  localparam logic [7:0] REG_GATE    = 8'h00;
  localparam logic [7:0] REG_INCR    = 8'h01;
  localparam logic [7:0] REG_WAVE    = 8'h04;
  localparam logic [7:0] REG_PW      = 8'h05;
  localparam logic [7:0] REG_ATTACK  = 8'h08;
  localparam logic [7:0] REG_DECAY   = 8'h0B;
  localparam logic [7:0] REG_SUSTAIN = 8'h0E;
  localparam logic [7:0] REG_RELEASE = 8'h11;
  localparam logic [7:0] REG_LINEAR  = 8'h14;

  // Index of each 24-bit field inside a voice's field array
  localparam int FLD_INCR    = 0;
  localparam int FLD_PW      = 1;
  localparam int FLD_ATTACK  = 2;
  localparam int FLD_DECAY   = 3;
  localparam int FLD_SUSTAIN = 4;
  localparam int FLD_RELEASE = 5;

  localparam logic [7:0] FIELD_BASE [NUM_FIELDS] =
    '{REG_INCR, REG_PW, REG_ATTACK, REG_DECAY, REG_SUSTAIN, REG_RELEASE};

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'b00,
    WAVE_SQUARE   = 2'b01,
    WAVE_TRIANGLE = 2'b10,
    WAVE_RESERVED = 2'b11
  } wave_t;

  // Which 24-bit field a register offset falls in, and which byte lane
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
    logic [1:0] lane;
  } field_sel_t;

  function automatic field_sel_t decode_field(input logic [15:0] reg_off);
    field_sel_t sel;
    sel = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (reg_off >= {8'h00, FIELD_BASE[i]} &&
          reg_off < ({8'h00, FIELD_BASE[i]} + 16'd3)) begin
        sel.hit  = 1'b1;
        sel.idx  = 3'(i);
        sel.lane = 2'(reg_off - {8'h00, FIELD_BASE[i]});
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/bus_clock_sync.sv
// Brings the asynchronous bus strobe into the system clock domain.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   async_in in  asynchronous strobe (BusClock)
//   level    out synchronised strobe level
//   rise     out one-cycle pulse on a synchronised rising edge
module bus_clock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic       s1, s2, s3;
  logic [1:0] warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      warm <= 2'd0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Edges are masked until the chain has refilled after reset, so a strobe
  // that was already high at reset release is not mistaken for a transfer.
  assign level = s2;
  assign rise  = s2 & ~s3 & (warm == 2'd3);

endmodule

// File: rtl/bus_reg_responder.sv
// Responder end of the synth register bus. Decodes byte writes into a
// per-voice register bank; 24-bit fields are staged in shadows and commit
// atomically on the high-byte write.
// Optional feature macro: READBACK_EN (tri-state readback on BusData).
// Ports:
//   Clock, Reset (async active-low)
//   BusAddress[15:0], BusData[7:0] (inout), BusReadWrite (1=write), BusClock
//   Gate, Linear        NUM_VOICES bits, one per voice
//   WaveType            2 bits per voice
//   Incr, PulseWidth, Attack, Decay, Sustain, Release  24 bits per voice
//   WriteStrobe         one-cycle pulse on any register commit
module bus_reg_responder
  import synth_bus_pkg::*;
#(
  parameter int          NUM_VOICES   = 2,
  parameter logic [15:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [15:0] VOICE_STRIDE = DEF_VOICE_STRIDE
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [15:0]                  BusAddress,
  inout  wire  [7:0]                   BusData,
  input  logic                         BusReadWrite,
  input  logic                         BusClock,
  output logic [NUM_VOICES-1:0]        Gate,
  output logic [FIELD_W*NUM_VOICES-1:0] Incr,
  output logic [2*NUM_VOICES-1:0]      WaveType,
  output logic [FIELD_W*NUM_VOICES-1:0] PulseWidth,
  output logic [FIELD_W*NUM_VOICES-1:0] Attack,
  output logic [FIELD_W*NUM_VOICES-1:0] Decay,
  output logic [FIELD_W*NUM_VOICES-1:0] Sustain,
  output logic [FIELD_W*NUM_VOICES-1:0] Release,
  output logic [NUM_VOICES-1:0]        Linear,
  output logic                         WriteStrobe
);

  logic bus_level, bus_edge;

  bus_clock_sync u_sync (
    .clk      (Clock),
    .rst_n    (Reset),
    .async_in (BusClock),
    .level    (bus_level),
    .rise     (bus_edge)
  );

  // Address decode; the bus holds address/data stable through the edge cycle
  logic [15:0] off, voice_idx, reg_off;
  logic        in_range, wr;
  logic        hit_gate, hit_wave, hit_lin;
  field_sel_t  fsel;
  logic [7:0]  wdata;

  assign in_range  = (BusAddress >= BASE_ADDR);
  assign off       = BusAddress - BASE_ADDR;
  assign voice_idx = off / VOICE_STRIDE;
  assign reg_off   = off % VOICE_STRIDE;
  assign fsel      = decode_field(reg_off);
  assign hit_gate  = (reg_off == {8'h00, REG_GATE});
  assign hit_wave  = (reg_off == {8'h00, REG_WAVE});
  assign hit_lin   = (reg_off == {8'h00, REG_LINEAR});
  assign wdata     = BusData;
  assign wr        = bus_edge & BusReadWrite & in_range;

  logic [NUM_VOICES-1:0]   voice_commit;
  logic [8*NUM_VOICES-1:0] rd_all;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [FIELD_W-1:0] field_q  [NUM_FIELDS];
    logic [15:0]        shadow_q [NUM_FIELDS];
    logic               gate_q, lin_q;
    logic [1:0]         wave_q;
    logic               sel;
    logic [7:0]         rd_v;

    assign sel = wr && (voice_idx == 16'(v));

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
          field_q[f]  <= '0;
          shadow_q[f] <= '0;
        end
        gate_q <= 1'b0;
        lin_q  <= 1'b0;
        wave_q <= 2'b00;
      end else if (sel) begin
        if (hit_gate) gate_q <= wdata[0];
        if (hit_wave) wave_q <= wdata[1:0];
        if (hit_lin)  lin_q  <= wdata[0];
        if (fsel.hit) begin
          case (fsel.lane)
            2'd0:    shadow_q[fsel.idx][7:0]  <= wdata;
            2'd1:    shadow_q[fsel.idx][15:8] <= wdata;
            // High byte: publish the staged lower bytes together with it
            default: field_q[fsel.idx] <= {wdata, shadow_q[fsel.idx]};
          endcase
        end
      end
    end

    assign voice_commit[v] = sel & (hit_gate | hit_wave | hit_lin |
                                    (fsel.hit & (fsel.lane == 2'd2)));

    // Readback shows committed values only; shadows are not visible
    always_comb begin
      rd_v = 8'h00;
      if (hit_gate) rd_v = {7'b0, gate_q};
      if (hit_wave) rd_v = {6'b0, wave_q};
      if (hit_lin)  rd_v = {7'b0, lin_q};
      if (fsel.hit) begin
        case (fsel.lane)
          2'd0:    rd_v = field_q[fsel.idx][7:0];
          2'd1:    rd_v = field_q[fsel.idx][15:8];
          default: rd_v = field_q[fsel.idx][23:16];
        endcase
      end
    end
    assign rd_all[8*v +: 8] = rd_v;

    assign Gate[v]                    = gate_q;
    assign Linear[v]                  = lin_q;
    assign WaveType[2*v +: 2]         = wave_q;
    assign Incr[FIELD_W*v +: FIELD_W]       = field_q[FLD_INCR];
    assign PulseWidth[FIELD_W*v +: FIELD_W] = field_q[FLD_PW];
    assign Attack[FIELD_W*v +: FIELD_W]     = field_q[FLD_ATTACK];
    assign Decay[FIELD_W*v +: FIELD_W]      = field_q[FLD_DECAY];
    assign Sustain[FIELD_W*v +: FIELD_W]    = field_q[FLD_SUSTAIN];
    assign Release[FIELD_W*v +: FIELD_W]    = field_q[FLD_RELEASE];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) WriteStrobe <= 1'b0;
    else        WriteStrobe <= |voice_commit;
  end

  logic [7:0] rd_data;
  always_comb begin
    rd_data = 8'h00;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (in_range && (voice_idx == 16'(v))) rd_data = rd_all[8*v +: 8];
    end
  end

`ifdef READBACK_EN
  assign BusData = (bus_level && !BusReadWrite) ? rd_data : 8'hzz;
`else
  // BusData stays input-only; readback path is left unconsumed
  logic unused_readback;
  assign unused_readback = bus_level ^ (^rd_data);
`endif

endmodule

// File: tb/tb_bus_reg_responder.sv
module tb_bus_reg_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic        bus_clk;
  logic [7:0]  tb_data;
  logic        tb_drive;
  wire  [7:0]  bus_data;

  logic [1:0]  gate, linear;
  logic [47:0] incr, pw, attack, decay, sustain, rel;
  logic [3:0]  wave;
  logic        strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int s0;

  assign bus_data = tb_drive ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  always @(posedge clk) if (strobe) strobe_cnt <= strobe_cnt + 1;

  bus_reg_responder dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .BusAddress   (bus_addr),
    .BusData      (bus_data),
    .BusReadWrite (bus_rw),
    .BusClock     (bus_clk),
    .Gate         (gate),
    .Incr         (incr),
    .WaveType     (wave),
    .PulseWidth   (pw),
    .Attack       (attack),
    .Decay        (decay),
    .Sustain      (sustain),
    .Release      (rel),
    .Linear       (linear),
    .WriteStrobe  (strobe)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a; tb_data = d; tb_drive = 1'b1; bus_rw = 1'b1; bus_clk = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with BusClock already high, then release
    rst_n = 1'b0; bus_clk = 1'b1; bus_addr = 16'h0010; bus_rw = 1'b1;
    tb_data = 8'h01; tb_drive = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_gate", {46'b0, gate}, 48'h0);
    check("rst_incr", incr, 48'h0);
    check("rst_wave", {44'b0, wave}, 48'h0);
    check("rst_env", attack | decay | sustain | rel | pw, 48'h0);
    check("rst_linear", {46'b0, linear}, 48'h0);
    check("rst_strobe_cnt", 48'(strobe_cnt), 48'd0);
    @(negedge clk) bus_clk = 1'b0;
    repeat (4) @(posedge clk);

    // 2: staged 24-bit write, exact commit latency
    s0 = strobe_cnt;
    bus_write(16'h0011, 8'hFF);
    check("incr_after_low", incr, 48'h0);
    bus_write(16'h0012, 8'hFF);
    check("incr_after_mid", incr, 48'h0);
    @(negedge clk);
    bus_addr = 16'h0013; tb_data = 8'h0F; bus_rw = 1'b1; bus_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("incr_edge2", incr, 48'h0);
    check("strobe_edge2", {47'b0, strobe}, 48'h0);
    @(posedge clk); #1;
    check("incr_edge3", incr, 48'h000000_0FFFFF);
    check("strobe_edge3", {47'b0, strobe}, 48'h1);
    @(posedge clk); #1;
    check("strobe_edge4", {47'b0, strobe}, 48'h0);
    @(negedge clk) bus_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("incr_strobe_count", 48'(strobe_cnt - s0), 48'd1);

    // shadows retained after commit
    bus_write(16'h0013, 8'h12);
    check("incr_shadow_keep", incr, 48'h000000_12FFFF);

    // 3: voice 1 single-byte fields
    bus_write(16'h0034, 8'h02);
    bus_write(16'h0030, 8'h01);
    check("wave_v1", {44'b0, wave}, 48'h8);
    check("gate_v1", {46'b0, gate}, 48'h2);

    // unused upper data bits ignored; last mapped offset
    bus_write(16'h0010, 8'h03);
    bus_write(16'h0024, 8'hFF);
    check("gate_v0", {46'b0, gate}, 48'h3);
    check("linear_v0", {46'b0, linear}, 48'h1);

    // 4: ignored addresses
    s0 = strobe_cnt;
    bus_write(16'h0000, 8'hAA);
    bus_write(16'h000F, 8'hAA);
    bus_write(16'h0025, 8'hAA);
    bus_write(16'h0050, 8'hAA);
    check("ign_gate", {46'b0, gate}, 48'h3);
    check("ign_wave", {44'b0, wave}, 48'h8);
    check("ign_incr", incr, 48'h000000_12FFFF);
    check("ign_linear", {46'b0, linear}, 48'h1);
    check("ign_env", attack | decay | sustain | rel | pw, 48'h0);
    check("ign_strobe_count", 48'(strobe_cnt - s0), 48'd0);

    // other fields / voices
    bus_write(16'h0035, 8'h11);
    bus_write(16'h0036, 8'h22);
    bus_write(16'h0037, 8'h33);
    check("pw_v1", pw, 48'h332211_000000);
    bus_write(16'h001B, 8'hAB);
    bus_write(16'h001C, 8'hCD);
    bus_write(16'h001D, 8'hEF);
    check("decay_v0", decay, 48'h000000_EFCDAB);
    bus_write(16'h0041, 8'h01);
    bus_write(16'h0042, 8'h02);
    bus_write(16'h0043, 8'h03);
    check("release_v1", rel, 48'h030201_000000);

    // 6: sustain commit and read cycle
    bus_write(16'h003E, 8'hFF);
    bus_write(16'h003F, 8'hFF);
    bus_write(16'h0040, 8'h7F);
    check("sustain_v1", sustain, 48'h7FFFFF_000000);
    s0 = strobe_cnt;
    @(negedge clk);
    tb_drive = 1'b0; bus_rw = 1'b0; bus_addr = 16'h0040; bus_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
`ifdef READBACK_EN
    check("read_sustain_hi", {40'b0, bus_data}, 48'h7F);
    @(negedge clk) bus_addr = 16'h0025;
    #1;
    check("read_unmapped", {40'b0, bus_data}, 48'h00);
`endif
    @(negedge clk) bus_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("read_no_strobe", 48'(strobe_cnt - s0), 48'd0);
    check("read_sustain_keep", sustain, 48'h7FFFFF_000000);

    // 5: reset clears shadows
    bus_write(16'h0018, 8'h55);
    bus_write(16'h0019, 8'h66);
    check("attack_staged", attack, 48'h0);
    pulse_reset();
    check("reset2_gate", {46'b0, gate}, 48'h0);
    check("reset2_fields", incr | sustain | pw, 48'h0);
    bus_write(16'h001A, 8'h01);
    check("attack_after_reset", attack, 48'h000000_010000);

    // reset mid-transfer aborts it
    s0 = strobe_cnt;
    @(negedge clk);
    bus_addr = 16'h0010; tb_data = 8'h01; tb_drive = 1'b1; bus_rw = 1'b1; bus_clk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus_clk = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_gate", {46'b0, gate}, 48'h0);
    check("abort_strobe_count", 48'(strobe_cnt - s0), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
